seq_shift_add_multiplier: RTL

- Sequential unsigned multiplier, one bit of the multiplier per clock, built around the team's WIDTH-bit ripple_carry_adder.
- Downstream consumer of the adder: it feeds the partial-product high half and the multiplicand into the adder, then shifts the adder's sum and c_out back into the accumulator.
- Gives a multi-cycle start/done multiply for the lab datapath without a combinational array multiplier.

---
 rtl/mult_pkg.sv | 17 +
 rtl/ripple_carry_adder.sv | 23 ++
 rtl/seq_shift_add_multiplier.sv | 106 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter must hold 0..WIDTH-1 plus headroom so it never wraps mid-operation.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[WIDTH];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned shift-add multiplier: one multiplier bit per clock, start/done handshake.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_sum;
    logic                 add_c_out;
    logic [WIDTH-1:0]     step_s;
    logic                 step_c;
    logic [2*WIDTH-1:0]   shifted;

    ripple_carry_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a    (acc_hi_q),
        .b    (mcand_q),
        .c_in (1'b0),
        .sum  (add_sum),
        .c_out(add_c_out)
    );

    // {c,s,acc_lo} >> 1: the carry becomes the new MSB, acc_lo[0] is consumed.
    always_comb begin
        step_s  = acc_lo_q[0] ? add_sum : acc_hi_q;
        step_c  = acc_lo_q[0] & add_c_out;
        shifted = {step_c, step_s, acc_lo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mcand_d  = a;
                    acc_hi_d = '0;
                    acc_lo_d = b;
                    count_d  = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                acc_hi_d = shifted[2*WIDTH-1:WIDTH];
                acc_lo_d = shifted[WIDTH-1:0];
                count_d  = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    product_d = shifted;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule
